// File: rtl/keypad_pkg.sv
// Shared keypad types: debounce FSM states, key-code width, operator codes
// and the scanner-to-logical key remap.
package keypad_pkg;

  localparam int unsigned KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } key_state_t;

  localparam logic [KEY_CODE_W-1:0] KEY_OP_A = 4'hA;
  localparam logic [KEY_CODE_W-1:0] KEY_OP_B = 4'hB;
  localparam logic [KEY_CODE_W-1:0] KEY_OP_C = 4'hC;
  localparam logic [KEY_CODE_W-1:0] KEY_OP_D = 4'hD;
  localparam logic [KEY_CODE_W-1:0] KEY_OP_E = 4'hE;
  localparam logic [KEY_CODE_W-1:0] KEY_OP_F = 4'hF;

  // Scanner matrix position to logical digit; operator keys pass through.
  function automatic logic [KEY_CODE_W-1:0] key_map(input logic [KEY_CODE_W-1:0] scan);
    case (scan)
      4'h0:     key_map = 4'h0;
      4'h1:     key_map = 4'h7;
      4'h2:     key_map = 4'h1;
      4'h3:     key_map = 4'h4;
      4'h4:     key_map = 4'h8;
      4'h5:     key_map = 4'h2;
      4'h6:     key_map = 4'h5;
      4'h7:     key_map = 4'h9;
      4'h8:     key_map = 4'h3;
      4'h9:     key_map = 4'h6;
      KEY_OP_A, KEY_OP_B, KEY_OP_C,
      KEY_OP_D, KEY_OP_E, KEY_OP_F: key_map = scan;
      default:  key_map = scan;
    endcase
  endfunction

  function automatic logic key_is_digit(input logic [KEY_CODE_W-1:0] code);
    key_is_digit = (code <= 4'd9);
  endfunction

endpackage

// File: rtl/module_debounce_counter.sv
// Loadable up-counter for the key debouncer; flags the terminal count
// combinationally so the FSM can act on the same edge.
module module_debounce_counter #(
  parameter int unsigned CNT_W    = 19,
  parameter int unsigned TC_VALUE = 269999
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_tc_c
);

  logic [CNT_W-1:0] r_count;

  // Saturates rather than wrapping if ever incremented past all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc_c = (r_count == CNT_W'(TC_VALUE));

endmodule

// File: rtl/module_key_event.sv
// Debounces the scanner's level key sample into one registered key event per
// physical press, with the logical (remapped) key code and a held flag.
module module_key_event
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_CODE_W-1:0] key_sample,
  input  logic                  key_detect,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_pulse,
  output logic                  key_held,
  output logic                  is_digit
);

  key_state_t            r_state;
  key_state_t            w_state_nxt;
  logic [KEY_CODE_W-1:0] r_candidate;
  logic [KEY_CODE_W-1:0] r_key_code;
  logic                  r_key_pulse;
  logic                  r_key_held;
  logic                  r_is_digit;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_cand_load;
  logic                  w_accept;
  logic                  w_release;
  logic                  w_tc;

  module_debounce_counter #(
    .CNT_W    (CNT_W),
    .TC_VALUE (DEBOUNCE_CYCLES - 1)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_tc_c  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter is cleared on every state change so each phase starts at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cand_load = 1'b0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_detect) begin
          w_cand_load = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (!key_detect) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = IDLE;
        end else if (key_sample != r_candidate) begin
          w_cand_load = 1'b1;
          w_cnt_clr   = 1'b1;
        end else if (w_tc) begin
          w_accept    = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = PRESSED;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      PRESSED: begin
        if (!key_detect) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (key_detect) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = PRESSED;
        end else if (w_tc) begin
          w_release   = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_candidate <= '0;
    end else if (w_cand_load) begin
      r_candidate <= key_sample;
    end
  end

  // Pulse lasts exactly the cycle after acceptance; code/digit hold until the next press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_code  <= '0;
      r_key_pulse <= 1'b0;
      r_key_held  <= 1'b0;
      r_is_digit  <= 1'b0;
    end else begin
      r_key_pulse <= w_accept;
      if (w_accept) begin
        r_key_code <= key_map(r_candidate);
        r_is_digit <= key_is_digit(key_map(r_candidate));
        r_key_held <= 1'b1;
      end else if (w_release) begin
        r_key_held <= 1'b0;
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_pulse = r_key_pulse;
  assign key_held  = r_key_held;
  assign is_digit  = r_is_digit;

endmodule
